// File: rtl/i2si_pkg.sv
// i2si_pkg: shared types and constants for the I2S input receiver.
package i2si_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, RECV} rx_state_t;
    localparam int SYNC_STAGES = 2;
    localparam int I2SI_BYTE_W = 8;
endpackage

// File: rtl/i2si_sync.sv
// i2si_sync: two-flop synchronizer bringing one asynchronous I2S pin into clk.
module i2si_sync
    import i2si_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] ff;
    always_ff @(posedge clk) ff <= rst ? '0 : {ff[SYNC_STAGES-2:0], d};
    assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/i2si_rx.sv
// i2si_rx: I2S serial receiver emitting each slot word MSB byte first on an rts/rtr handshake.
// Define I2SI_MONO_EN to emit only left-channel words.
module i2si_rx
    import i2si_pkg::*;
#(
    parameter int WORD_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   i2s_sck,
    input  logic                   i2s_ws,
    input  logic                   i2s_sd,
    output logic [I2SI_BYTE_W-1:0] out_data,
    output logic                   out_rts,
    input  logic                   out_rtr,
    output logic                   overrun
);
    localparam int CW = $clog2(WORD_BITS + 1);
    localparam int BN = WORD_BITS / I2SI_BYTE_W;
    localparam int BW = $clog2(BN + 1);
    localparam logic [CW-1:0] WB_C = CW'(WORD_BITS);
    localparam logic [BW-1:0] BN_C = BW'(BN);

    rx_state_t state, state_n;
    logic sck_s, ws_s, sd_s, sck_d, ws_prev;
    logic bit_evt, ws_chg, word_done, accept, xfer, hold_free;
    logic [CW-1:0] bit_cnt, cnt_n;
    logic [WORD_BITS-1:0] shreg, sh_n, word, hold;
    logic [BW-1:0] byte_cnt;

    i2si_sync u_sck (.clk(clk), .rst(rst), .d(i2s_sck), .q(sck_s));
    i2si_sync u_ws  (.clk(clk), .rst(rst), .d(i2s_ws),  .q(ws_s));
    i2si_sync u_sd  (.clk(clk), .rst(rst), .d(i2s_sd),  .q(sd_s));

    assign bit_evt   = sck_s & ~sck_d;
    assign ws_chg    = bit_evt && (ws_s != ws_prev);
    assign word_done = enable && state == RECV && ws_chg;
`ifdef I2SI_MONO_EN
    assign accept    = word_done && !ws_prev;
`else
    assign accept    = word_done;
`endif
    assign xfer      = out_rts && out_rtr;
    assign hold_free = byte_cnt == '0 || (xfer && byte_cnt == BW'(1));
    assign out_rts   = byte_cnt != '0;
    assign out_data  = hold[WORD_BITS-1 -: I2SI_BYTE_W];

    always_ff @(posedge clk) state <= rst ? (enable ? SYNC : IDLE) : state_n;

    // Saturated count keeps only the first WORD_BITS bits; the shift MSB-aligns short slots.
    always_comb begin
        state_n = !enable ? IDLE : state == IDLE ? SYNC : (state == SYNC && ws_chg) ? RECV : state;
        sh_n    = bit_cnt == WB_C ? shreg : {shreg[WORD_BITS-2:0], sd_s};
        cnt_n   = bit_cnt == WB_C ? WB_C : bit_cnt + 1'b1;
        word    = sh_n << (WB_C - cnt_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_d   <= 1'b0;
            ws_prev <= 1'b0;
        end else begin
            sck_d <= sck_s;
            if (bit_evt) ws_prev <= ws_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable || state != RECV || ws_chg) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (bit_evt) begin
            shreg   <= sh_n;
            bit_cnt <= cnt_n;
        end
    end

    // A final-byte transfer frees hold in the same cycle a new word arrives.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            hold     <= '0;
            byte_cnt <= '0;
            overrun  <= 1'b0;
        end else if (accept && hold_free) begin
            hold     <= word;
            byte_cnt <= BN_C;
        end else begin
            if (accept) overrun <= 1'b1;
            if (xfer) begin
                hold     <= hold << I2SI_BYTE_W;
                byte_cnt <= byte_cnt - 1'b1;
            end
        end
    end
endmodule
